mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Port list SHALL be: clk input 1 (system clock, rising-edge active).
REQ-002 Port list SHALL include: reset input 1 (synchronous, active-high; one clock; reset is synchronous and active-high).
REQ-003 IRM input 32: instruction currently in M stage.
REQ-004 PC4M input 32: PC+4 of that instruction.
REQ-005 AOM input 32: ALU result, which is the effective address for loads and stores.
REQ-006 WDM input 32: store data, already forwarded.
REQ-007 IRW output 32: registered IRM.
REQ-008 PC4W output 32: registered PC4M.
REQ-009 AOW output 32: registered AOM.
REQ-010 DRW output 32: registered, extended load data.

Function
REQ-011 Data memory SHALL be 1024 x 32-bit words, indexed by AOM[11:2]; AOM[31:12] ignored.
REQ-012 Opcodes decoded from IRM[31:26]: lw 0x23, lb 0x20, lbu 0x24, lh 0x21, lhu 0x25, sw 0x2B, sh 0x29, sb 0x28; all other opcodes neither read nor write memory.
REQ-013 Store SHALL write on the rising clk edge ending the instruction's M cycle.
- sw: writes full word; ignores AOM[1:0].
- sh: writes WDM[15:0] into halfword AOM[1] (1 = bits 31:16); ignores AOM[0].
- sb: writes WDM[7:0] into byte lane AOM[1:0] (3 = bits 31:24).
- Unselected lanes unchanged.
REQ-014 Load read SHALL be combinational from memory state at start of the M cycle; selected data SHALL be registered into DRW at the same edge.
- Total load latency: one cycle, M to W.
REQ-015 Load extension:
- lw: word, ignores AOM[1:0].
- lh / lhu: halfword at AOM[1], sign-extended / zero-extended.
- lb / lbu: byte at AOM[1:0], sign-extended / zero-extended.
REQ-016 For non-load instructions DRW SHALL still load the lw-style word read at AOM[11:2]; W ignores it.
REQ-017 IRW, PC4W and AOW SHALL capture IRM, PC4M and AOM every non-reset edge; no stall, no enable; flush is by upstream injecting 0 (nop).
REQ-018 A load in cycle N+1 to an address stored in cycle N SHALL return the newly stored data.
- No bypass is needed, since the write completed at the edge.
REQ-019 A single instruction SHALL never both read and write; no same-cycle read/write hazard exists.

Reset
REQ-020 When reset is high at a clk edge:
- IRW, PC4W, AOW and DRW SHALL become 0.
- All 1024 memory words SHALL become 0.
REQ-021 Reset SHALL take priority over a simultaneous store; that store is discarded.
REQ-022 Outputs SHALL be 0 from the first edge with reset high until the first edge after reset deasserts.

Structure
REQ-023 Opcode values and instruction field ranges (OpCode, rs, rt, rd, Funct) SHALL live in the shared header, not locally.
REQ-024 Memory array, byte-lane write logic and load extension SHALL be one sub-module, dm.
- mem_stage SHALL hold only the pipeline register and the dm instance.

Verification
REQ-025 Bench SHALL cover: reset, then sw with AOM=0x00000010, WDM=0xDEADBEEF, then lw from 0x10 -> DRW=0xDEADBEEF one cycle after the lw is in M.
REQ-026 Bench SHALL cover: from word 0xDEADBEEF at 0x10, run lb 0x13, lbu 0x13, lh 0x12, lhu 0x10.
- Required DRW: 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000BEEF.
REQ-027 Bench SHALL cover: sb WDM=0x12345678 to 0x11, then sh WDM=0xAAAA5555 to 0x12, then lw 0x10.
- Required DRW: 0x555578EF.
REQ-028 Bench SHALL cover: sw 0xFFFFFFFF to AOM=0x00001004, then lw 0x00000004 -> DRW=0xFFFFFFFF (address alias).
REQ-029 Bench SHALL cover: reset asserted in the same cycle as sw 0x11111111 to 0x20, then lw 0x20 -> DRW=0.
- IRW, PC4W, AOW and DRW SHALL read 0 during reset.
REQ-030 Bench SHALL cover: a non-memory instruction (IRM=0x00221820, addu) with PC4M=0x3004, AOM=0x7.
- Required next cycle: IRW=0x00221820, PC4W=0x3004, AOW=0x7; memory unchanged.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared instruction-field ranges, memory opcodes and decode for the M stage.
package mem_stage_pkg;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SB  = 6'h28;

  localparam int DM_WORDS  = 1024;
  localparam int DM_ADDR_W = 12;

  typedef enum logic [3:0] {
    MEM_NONE, MEM_LW, MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_SW, MEM_SH, MEM_SB
  } mem_op_e;

  function automatic mem_op_e decode_mem_op(input logic [5:0] opcode);
    case (opcode)
      OP_LW:   return MEM_LW;
      OP_LB:   return MEM_LB;
      OP_LBU:  return MEM_LBU;
      OP_LH:   return MEM_LH;
      OP_LHU:  return MEM_LHU;
      OP_SW:   return MEM_SW;
      OP_SH:   return MEM_SH;
      OP_SB:   return MEM_SB;
      default: return MEM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_dm.sv
// Data memory: 1024 words, byte/halfword lane stores, combinational extended load.
module dm
  import mem_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  mem_op_e              op,
  input  logic [DM_ADDR_W-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [DM_WORDS];
  logic [9:0]  idx;
  logic [31:0] word;

  assign idx  = addr[11:2];
  assign word = mem[idx];

  function automatic logic [31:0] extend_load(input mem_op_e o, input logic [1:0] lane,
                                              input logic [31:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = $signed(w[8*lane +: 8]);
    h = $signed(lane[1] ? w[31:16] : w[15:0]);
    case (o)
      MEM_LB:  return 32'($signed(b));
      MEM_LBU: return {24'h0, b};
      MEM_LH:  return 32'($signed(h));
      MEM_LHU: return {16'h0, h};
      default: return w;
    endcase
  endfunction

  assign rdata = extend_load(op, addr[1:0], word);

  // Reset clears the whole array and overrides any store in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) mem[i] <= '0;
    end else begin
      case (op)
        MEM_SW: mem[idx] <= wdata;
        MEM_SH: begin
          if (addr[1]) mem[idx][31:16] <= wdata[15:0];
          else         mem[idx][15:0]  <= wdata[15:0];
        end
        MEM_SB: mem[idx][8*addr[1:0] +: 8] <= wdata[7:0];
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// M-to-W pipeline register around the data memory.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IRM,
  input  logic [31:0] PC4M,
  input  logic [31:0] AOM,
  input  logic [31:0] WDM,
  output logic [31:0] IRW,
  output logic [31:0] PC4W,
  output logic [31:0] AOW,
  output logic [31:0] DRW
);

  mem_op_e     op_p0;
  logic [31:0] ld_data_p0;

  assign op_p0 = decode_mem_op(IRM[OPCODE_HI:OPCODE_LO]);

  dm u_dm (
    .clk   (clk),
    .reset (reset),
    .op    (op_p0),
    .addr  (AOM[DM_ADDR_W-1:0]),
    .wdata (WDM),
    .rdata (ld_data_p0)
  );

  // p0 -> p1: M/W boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      IRW  <= '0;
      PC4W <= '0;
      AOW  <= '0;
      DRW  <= '0;
    end else begin
      IRW  <= IRM;
      PC4W <= PC4M;
      AOW  <= AOM;
      DRW  <= ld_data_p0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected W-stage values queued per vector.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IRM, PC4M, AOM, WDM;
  logic [31:0] IRW, PC4W, AOW, DRW;

  localparam logic [5:0] LW = 6'h23, LB = 6'h20, LBU = 6'h24, LH = 6'h21,
                         LHU = 6'h25, SW = 6'h2B, SH = 6'h29, SB = 6'h28;

  typedef struct packed {
    logic        chk_drw;
    logic [31:0] irw, pc4w, aow, drw;
  } exp_t;

  typedef struct packed {
    logic [31:0] irw, pc4w, aow, drw;
  } obs_t;

  exp_t  exp_q[$];
  obs_t  obs_q[$];
  string name_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  logic [31:0] pc = 32'h3000;

  mem_stage dut (
    .clk(clk), .reset(reset), .IRM(IRM), .PC4M(PC4M), .AOM(AOM), .WDM(WDM),
    .IRW(IRW), .PC4W(PC4W), .AOW(AOW), .DRW(DRW)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mk(input logic [5:0] opc);
    return {opc, 26'h0};
  endfunction

  // Drive one instruction through M, queue its expected W values, capture W after the edge.
  task automatic apply(input string nm, input logic r, input logic [31:0] ir,
                       input logic [31:0] ao, input logic [31:0] wd,
                       input logic chk, input logic [31:0] exp_drw);
    exp_t e;
    obs_t o;
    @(negedge clk);
    pc    = pc + 32'd4;
    reset = r;
    IRM   = ir;
    PC4M  = pc;
    AOM   = ao;
    WDM   = wd;
    if (r) e = '{chk_drw: 1'b1, irw: 32'h0, pc4w: 32'h0, aow: 32'h0, drw: 32'h0};
    else   e = '{chk_drw: chk, irw: ir, pc4w: pc, aow: ao, drw: exp_drw};
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    o = '{irw: IRW, pc4w: PC4W, aow: AOW, drw: DRW};
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    exp_t e; obs_t o; string nm;
    apply("reset0", 1'b1, mk(SW), 32'h10, 32'h5A5A5A5A, 1'b1, 32'h0);
    apply("reset1", 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0);
    apply("post_reset_lw", 1'b0, mk(LW), 32'h10, 32'h0, 1'b1, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      vectors += 4;
      if (o.irw !== e.irw)   begin miscompares++; $display("FAIL %s IRW got %h exp %h", nm, o.irw, e.irw); end
      if (o.pc4w !== e.pc4w) begin miscompares++; $display("FAIL %s PC4W got %h exp %h", nm, o.pc4w, e.pc4w); end
      if (o.aow !== e.aow)   begin miscompares++; $display("FAIL %s AOW got %h exp %h", nm, o.aow, e.aow); end
      if (o.drw !== e.drw)   begin miscompares++; $display("FAIL %s DRW got %h exp %h", nm, o.drw, e.drw); end
    end
  endtask

  task automatic test_sw_lw();
    exp_t e; obs_t o; string nm;
    apply("sw_10", 1'b0, mk(SW), 32'h10, 32'hDEADBEEF, 1'b1, 32'h0);
    apply("lw_10", 1'b0, mk(LW), 32'h10, 32'h0, 1'b1, 32'hDEADBEEF);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      vectors += 3;
      if (o.irw !== e.irw)   begin miscompares++; $display("FAIL %s IRW got %h exp %h", nm, o.irw, e.irw); end
      if (o.aow !== e.aow)   begin miscompares++; $display("FAIL %s AOW got %h exp %h", nm, o.aow, e.aow); end
      if (o.drw !== e.drw)   begin miscompares++; $display("FAIL %s DRW got %h exp %h", nm, o.drw, e.drw); end
    end
  endtask

  task automatic test_load_extend();
    exp_t e; obs_t o; string nm;
    apply("lb_13",  1'b0, mk(LB),  32'h13, 32'h0, 1'b1, 32'hFFFFFFDE);
    apply("lbu_13", 1'b0, mk(LBU), 32'h13, 32'h0, 1'b1, 32'h000000DE);
    apply("lh_12",  1'b0, mk(LH),  32'h12, 32'h0, 1'b1, 32'hFFFFDEAD);
    apply("lhu_10", 1'b0, mk(LHU), 32'h10, 32'h0, 1'b1, 32'h0000BEEF);
    apply("lb_10",  1'b0, mk(LB),  32'h10, 32'h0, 1'b1, 32'hFFFFFFEF);
    apply("lbu_11", 1'b0, mk(LBU), 32'h11, 32'h0, 1'b1, 32'h000000BE);
    apply("lw_13",  1'b0, mk(LW),  32'h13, 32'h0, 1'b1, 32'hDEADBEEF);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      vectors++;
      if (o.drw !== e.drw) begin miscompares++; $display("FAIL %s DRW got %h exp %h", nm, o.drw, e.drw); end
    end
  endtask

  task automatic test_partial_store();
    exp_t e; obs_t o; string nm;
    apply("sb_11", 1'b0, mk(SB), 32'h11, 32'h12345678, 1'b1, 32'hDEADBEEF);
    apply("sh_12", 1'b0, mk(SH), 32'h12, 32'hAAAA5555, 1'b1, 32'hDEAD78EF);
    apply("lw_10", 1'b0, mk(LW), 32'h10, 32'h0, 1'b1, 32'h555578EF);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      vectors++;
      if (o.drw !== e.drw) begin miscompares++; $display("FAIL %s DRW got %h exp %h", nm, o.drw, e.drw); end
    end
  endtask

  task automatic test_alias();
    exp_t e; obs_t o; string nm;
    apply("sw_1004", 1'b0, mk(SW), 32'h00001004, 32'hFFFFFFFF, 1'b1, 32'h0);
    apply("lw_0004", 1'b0, mk(LW), 32'h00000004, 32'h0, 1'b1, 32'hFFFFFFFF);
    apply("lw_ff010", 1'b0, mk(LW), 32'hFFFFF010, 32'h0, 1'b1, 32'h555578EF);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      vectors += 2;
      if (o.aow !== e.aow) begin miscompares++; $display("FAIL %s AOW got %h exp %h", nm, o.aow, e.aow); end
      if (o.drw !== e.drw) begin miscompares++; $display("FAIL %s DRW got %h exp %h", nm, o.drw, e.drw); end
    end
  endtask

  task automatic test_reset_store();
    exp_t e; obs_t o; string nm;
    apply("rst_sw_20", 1'b1, mk(SW), 32'h20, 32'h11111111, 1'b1, 32'h0);
    apply("lw_20", 1'b0, mk(LW), 32'h20, 32'h0, 1'b1, 32'h0);
    apply("lw_10_cleared", 1'b0, mk(LW), 32'h10, 32'h0, 1'b1, 32'h0);
    apply("lw_04_cleared", 1'b0, mk(LW), 32'h04, 32'h0, 1'b1, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      vectors += 4;
      if (o.irw !== e.irw)   begin miscompares++; $display("FAIL %s IRW got %h exp %h", nm, o.irw, e.irw); end
      if (o.pc4w !== e.pc4w) begin miscompares++; $display("FAIL %s PC4W got %h exp %h", nm, o.pc4w, e.pc4w); end
      if (o.aow !== e.aow)   begin miscompares++; $display("FAIL %s AOW got %h exp %h", nm, o.aow, e.aow); end
      if (o.drw !== e.drw)   begin miscompares++; $display("FAIL %s DRW got %h exp %h", nm, o.drw, e.drw); end
    end
  endtask

  task automatic test_nonmem();
    exp_t e; obs_t o; string nm;
    apply("sw_04", 1'b0, mk(SW), 32'h04, 32'hCAFEF00D, 1'b1, 32'h0);
    @(negedge clk);
    pc = 32'h3000;
    apply("addu", 1'b0, 32'h00221820, 32'h7, 32'h12345678, 1'b1, 32'hCAFEF00D);
    apply("lw_04_after", 1'b0, mk(LW), 32'h04, 32'h0, 1'b1, 32'hCAFEF00D);
    apply("nop_00", 1'b0, 32'h0, 32'h00, 32'hFFFFFFFF, 1'b1, 32'h0);
    apply("lw_00_after", 1'b0, mk(LW), 32'h00, 32'h0, 1'b1, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      vectors += 4;
      if (o.irw !== e.irw)   begin miscompares++; $display("FAIL %s IRW got %h exp %h", nm, o.irw, e.irw); end
      if (o.pc4w !== e.pc4w) begin miscompares++; $display("FAIL %s PC4W got %h exp %h", nm, o.pc4w, e.pc4w); end
      if (o.aow !== e.aow)   begin miscompares++; $display("FAIL %s AOW got %h exp %h", nm, o.aow, e.aow); end
      if (o.drw !== e.drw)   begin miscompares++; $display("FAIL %s DRW got %h exp %h", nm, o.drw, e.drw); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; obs_t o; string nm;
    apply("sb_40", 1'b0, mk(SB), 32'h40, 32'h000000A1, 1'b1, 32'h0);
    apply("sb_41", 1'b0, mk(SB), 32'h41, 32'h000000B2, 1'b1, 32'h000000A1);
    apply("sb_42", 1'b0, mk(SB), 32'h42, 32'h000000C3, 1'b1, 32'h0000B2A1);
    apply("sb_43", 1'b0, mk(SB), 32'h43, 32'h000000D4, 1'b1, 32'h00C3B2A1);
    apply("lw_40", 1'b0, mk(LW), 32'h40, 32'h0, 1'b1, 32'hD4C3B2A1);
    apply("lh_40", 1'b0, mk(LH), 32'h40, 32'h0, 1'b1, 32'hFFFFB2A1);
    apply("lhu_42", 1'b0, mk(LHU), 32'h42, 32'h0, 1'b1, 32'h0000D4C3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      vectors += 2;
      if (o.pc4w !== e.pc4w) begin miscompares++; $display("FAIL %s PC4W got %h exp %h", nm, o.pc4w, e.pc4w); end
      if (o.drw !== e.drw)   begin miscompares++; $display("FAIL %s DRW got %h exp %h", nm, o.drw, e.drw); end
    end
  endtask

  initial begin
    reset = 1'b1;
    IRM = '0; PC4M = '0; AOM = '0; WDM = '0;
    test_reset();
    test_sw_lw();
    test_load_extend();
    test_partial_store();
    test_alias();
    test_reset_store();
    test_nonmem();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
